// File: rtl/llc_lookup_way_pipe.sv
// LLC way-lookup stage: resolves hit / empty way / eviction victim for one set and holds
// results in a two-entry skid buffer, with flush and saturating hit/evict statistics.
module llc_lookup_way_pipe #(
    parameter int                    WAYS       = 16,
    parameter int                    WAY_BITS   = 4,
    parameter int                    TAG_BITS   = 12,
    parameter int                    SET_BITS   = 9,
    parameter int                    STATE_BITS = 3,
    parameter logic [STATE_BITS-1:0] ST_INVALID = STATE_BITS'(0),
    parameter logic [STATE_BITS-1:0] ST_VALID   = STATE_BITS'(1),
    parameter logic [STATE_BITS-1:0] ST_SD      = STATE_BITS'(4),
    parameter int                    CNT_BITS   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WAYS*TAG_BITS-1:0]       in_tags,
    input  logic [WAYS*STATE_BITS-1:0]     in_states,
    input  logic [WAY_BITS-1:0]            in_evict_base,
    input  logic [TAG_BITS-1:0]            in_tag,
    input  logic [SET_BITS-1:0]            in_set,
    input  logic                           flush,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WAY_BITS-1:0]            out_way,
    output logic                           out_hit,
    output logic                           out_evict,
    output logic [TAG_BITS+SET_BITS-1:0]   out_addr_evict,
    output logic [CNT_BITS-1:0]            hit_cnt,
    output logic [CNT_BITS-1:0]            evict_cnt,
    input  logic                           cnt_clr
);

    localparam int ADDR_BITS = TAG_BITS + SET_BITS;

    // Resolve signals
    logic                  any_hit, any_empty, any_valid, any_notsd;
    logic [WAY_BITS-1:0]   hit_way, empty_way, valid_way, notsd_way;
    logic [WAY_BITS-1:0]   rot;
    logic [STATE_BITS-1:0] st_i, st_j;
    logic [TAG_BITS-1:0]   tag_i;
    logic [WAY_BITS-1:0]   res_way;
    logic                  res_hit, res_evict;
    logic [ADDR_BITS-1:0]  res_addr;

    // Pipeline entries
    logic                  main_v, skid_v;
    logic [WAY_BITS-1:0]   main_way, skid_way;
    logic                  main_hit, skid_hit;
    logic                  main_evict, skid_evict;
    logic [ADDR_BITS-1:0]  main_addr, skid_addr;

    logic                  push, pop;

    // Scan from the top way down so the last match written is the lowest index.
    always_comb begin
        any_hit   = 1'b0;
        any_empty = 1'b0;
        any_valid = 1'b0;
        any_notsd = 1'b0;
        hit_way   = '0;
        empty_way = '0;
        valid_way = '0;
        notsd_way = '0;
        rot       = '0;
        st_i      = '0;
        st_j      = '0;
        tag_i     = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            rot   = WAY_BITS'(i) + in_evict_base;
            st_i  = in_states[i*STATE_BITS +: STATE_BITS];
            st_j  = in_states[int'(rot)*STATE_BITS +: STATE_BITS];
            tag_i = in_tags[i*TAG_BITS +: TAG_BITS];
            if (tag_i == in_tag && st_i != ST_INVALID) begin
                any_hit = 1'b1;
                hit_way = WAY_BITS'(i);
            end
            if (st_i == ST_INVALID) begin
                any_empty = 1'b1;
                empty_way = WAY_BITS'(i);
            end
            if (st_j == ST_VALID) begin
                any_valid = 1'b1;
                valid_way = rot;
            end
            if (st_j != ST_SD) begin
                any_notsd = 1'b1;
                notsd_way = rot;
            end
        end
    end

    always_comb begin
        res_way   = in_evict_base;
        res_hit   = 1'b0;
        res_evict = 1'b1;
        if (any_hit) begin
            res_way   = hit_way;
            res_hit   = 1'b1;
            res_evict = 1'b0;
        end else if (any_empty) begin
            res_way   = empty_way;
            res_evict = 1'b0;
        end else if (any_valid) begin
            res_way   = valid_way;
        end else if (any_notsd) begin
            res_way   = notsd_way;
        end
        res_addr = {in_tags[int'(res_way)*TAG_BITS +: TAG_BITS], in_set};
    end

    // Handshake: a beat transfers when valid && ready on the same edge. in_ready comes
    // only from the registered skid flag (plus flush, which drops the beat), never from
    // out_ready. out_* hold steady while out_valid && !out_ready.
    assign in_ready = !skid_v || flush;
    assign push     = in_valid && in_ready && !flush;
    assign pop      = main_v && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_v     <= 1'b0;
            skid_v     <= 1'b0;
            main_way   <= '0;
            main_hit   <= 1'b0;
            main_evict <= 1'b0;
            main_addr  <= '0;
            skid_way   <= '0;
            skid_hit   <= 1'b0;
            skid_evict <= 1'b0;
            skid_addr  <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (pop) begin
            if (skid_v) begin
                main_way   <= skid_way;
                main_hit   <= skid_hit;
                main_evict <= skid_evict;
                main_addr  <= skid_addr;
                skid_v     <= 1'b0;
            end else if (push) begin
                main_way   <= res_way;
                main_hit   <= res_hit;
                main_evict <= res_evict;
                main_addr  <= res_addr;
            end else begin
                main_v <= 1'b0;
            end
        end else if (push) begin
            if (main_v) begin
                skid_v     <= 1'b1;
                skid_way   <= res_way;
                skid_hit   <= res_hit;
                skid_evict <= res_evict;
                skid_addr  <= res_addr;
            end else begin
                main_v     <= 1'b1;
                main_way   <= res_way;
                main_hit   <= res_hit;
                main_evict <= res_evict;
                main_addr  <= res_addr;
            end
        end
    end

    assign out_valid      = main_v;
    assign out_way        = main_way;
    assign out_hit        = main_hit;
    assign out_evict      = main_evict;
    assign out_addr_evict = main_addr;

    // Statistics count consumed results; clear wins over increment, flush is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt   <= '0;
            evict_cnt <= '0;
        end else if (cnt_clr) begin
            hit_cnt   <= '0;
            evict_cnt <= '0;
        end else if (pop) begin
            if (main_hit && hit_cnt != '1)
                hit_cnt <= hit_cnt + CNT_BITS'(1);
            if (main_evict && evict_cnt != '1)
                evict_cnt <= evict_cnt + CNT_BITS'(1);
        end
    end

endmodule

// File: tb/tb_llc_lookup_way_pipe.sv
// Bench for llc_lookup_way_pipe: directed vector table, skid/flush/counter/reset
// sequences, and randomized traffic checked against a rule-level reference model.
module tb_llc_lookup_way_pipe;

    localparam int WAYS = 4;
    localparam int WB   = 2;
    localparam int TB   = 8;
    localparam int SB   = 5;
    localparam int STB  = 3;
    localparam int CB   = 4;
    localparam int AW   = TB + SB;
    localparam int RW   = WB + 2 + AW;
    localparam int CMAX = (1 << CB) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [WAYS*TB-1:0]   in_tags;
    logic [WAYS*STB-1:0]  in_states;
    logic [WB-1:0]        in_evict_base;
    logic [TB-1:0]        in_tag;
    logic [SB-1:0]        in_set;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [WB-1:0]        out_way;
    logic                 out_hit;
    logic                 out_evict;
    logic [AW-1:0]        out_addr_evict;
    logic [CB-1:0]        hit_cnt;
    logic [CB-1:0]        evict_cnt;
    logic                 cnt_clr;

    llc_lookup_way_pipe #(
        .WAYS(WAYS), .WAY_BITS(WB), .TAG_BITS(TB), .SET_BITS(SB),
        .STATE_BITS(STB), .ST_INVALID(3'd0), .ST_VALID(3'd1), .ST_SD(3'd4),
        .CNT_BITS(CB)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_tags(in_tags), .in_states(in_states), .in_evict_base(in_evict_base),
        .in_tag(in_tag), .in_set(in_set), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_way(out_way), .out_hit(out_hit), .out_evict(out_evict),
        .out_addr_evict(out_addr_evict),
        .hit_cnt(hit_cnt), .evict_cnt(evict_cnt), .cnt_clr(cnt_clr)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    int                total = 0;
    int                bad   = 0;
    logic [RW-1:0]     exp_q[$];
    int                m_hit;
    int                m_evict;
    int                pop_cnt;
    bit                acc_flag;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // Reference: apply the lookup rules in order over plain arrays.
    function automatic logic [RW-1:0] ref_resolve(input logic [WAYS*TB-1:0] tg,
                                                  input logic [WAYS*STB-1:0] st,
                                                  input logic [TB-1:0] rt,
                                                  input logic [WB-1:0] base,
                                                  input logic [SB-1:0] set);
        logic [TB-1:0]  t[WAYS];
        logic [STB-1:0] s[WAYS];
        int  way, k;
        bit  hit, ev, found;
        for (int i = 0; i < WAYS; i++) begin
            t[i] = tg[TB*i +: TB];
            s[i] = st[STB*i +: STB];
        end
        found = 0; hit = 0; ev = 0; way = 0;
        for (int i = 0; i < WAYS; i++)
            if (!found && s[i] != 3'd0 && t[i] == rt) begin found = 1; hit = 1; way = i; end
        for (int i = 0; i < WAYS; i++)
            if (!found && s[i] == 3'd0) begin found = 1; way = i; end
        for (int i = 0; i < WAYS; i++) begin
            k = (i + int'(base)) % WAYS;
            if (!found && s[k] == 3'd1) begin found = 1; ev = 1; way = k; end
        end
        for (int i = 0; i < WAYS; i++) begin
            k = (i + int'(base)) % WAYS;
            if (!found && s[k] != 3'd4) begin found = 1; ev = 1; way = k; end
        end
        if (!found) begin ev = 1; way = int'(base); end
        return {WB'(way), hit, ev, t[way], set};
    endfunction

    // One clock cycle: inputs already driven at the negedge.
    task automatic tick();
        logic [RW-1:0] got, expv;
        #1;
        acc_flag = 0;
        if (out_valid && out_ready) begin
            got = {out_way, out_hit, out_evict, out_addr_evict};
            pop_cnt++;
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", got, '0);
                if (got == '0) begin bad++; $display("FAIL pop_unexpected: actual=pop expected=none"); end
            end else begin
                expv = exp_q.pop_front();
                chk("pop_result", got, expv);
                if (expv[RW-WB-1] && m_hit < CMAX) m_hit++;
                if (expv[RW-WB-2] && m_evict < CMAX) m_evict++;
            end
        end
        if (in_valid && in_ready && !flush) begin
            exp_q.push_back(ref_resolve(in_tags, in_states, in_tag, in_evict_base, in_set));
            acc_flag = 1;
        end
        if (flush) exp_q.delete();
        if (cnt_clr) begin m_hit = 0; m_evict = 0; end
        @(negedge clk);
        chk("hit_cnt", hit_cnt, m_hit);
        chk("evict_cnt", evict_cnt, m_evict);
    endtask

    task automatic drive_req(input logic [WAYS*TB-1:0] tg, input logic [WAYS*STB-1:0] st,
                             input logic [TB-1:0] rt, input logic [WB-1:0] base,
                             input logic [SB-1:0] set);
        in_valid      = 1'b1;
        in_tags       = tg;
        in_states     = st;
        in_tag        = rt;
        in_evict_base = base;
        in_set        = set;
    endtask

    task automatic drain(input string name);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk({name, "_queue_empty"}, exp_q.size(), 0);
        chk({name, "_out_valid"}, out_valid, 0);
    endtask

    typedef struct {
        logic [WAYS*TB-1:0]  tags;
        logic [WAYS*STB-1:0] states;
        logic [WB-1:0]       base;
        logic [TB-1:0]       tag;
        logic [SB-1:0]       set;
        logic [WB-1:0]       way;
        logic                hit;
        logic                evict;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [WAYS*TB-1:0] tg;
        logic [TB-1:0]      et;
        logic [WAYS*STB-1:0] st;

        // Directed vectors; states written way3..way0 as octal digits.
        vecs[0] = '{32'h44332211, 12'o1111, 2'd0, 8'h33, 5'd7,  2'd2, 1'b1, 1'b0};
        vecs[1] = '{32'h44332211, 12'o0101, 2'd0, 8'h55, 5'd3,  2'd1, 1'b0, 1'b0};
        vecs[2] = '{32'h44332211, 12'o4144, 2'd3, 8'h55, 5'd9,  2'd2, 1'b0, 1'b1};
        vecs[3] = '{32'h44332211, 12'o4444, 2'd3, 8'h55, 5'd17, 2'd3, 1'b0, 1'b1};
        vecs[4] = '{32'h44332211, 12'o1111, 2'd1, 8'h55, 5'd31, 2'd1, 1'b0, 1'b1};
        vecs[5] = '{32'h44332211, 12'o2424, 2'd2, 8'h55, 5'd1,  2'd3, 1'b0, 1'b1};
        vecs[6] = '{32'h33333333, 12'o1110, 2'd3, 8'h33, 5'd12, 2'd1, 1'b1, 1'b0};
        vecs[7] = '{32'h44332211, 12'o1111, 2'd2, 8'h44, 5'd20, 2'd3, 1'b1, 1'b0};

        // Clock/reset
        rst = 1'b0; in_valid = 0; in_tags = '0; in_states = '0; in_evict_base = '0;
        in_tag = '0; in_set = '0; flush = 0; out_ready = 0; cnt_clr = 0;
        m_hit = 0; m_evict = 0; pop_cnt = 0; acc_flag = 0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_way", out_way, 0);
        chk("rst_out_hit", out_hit, 0);
        chk("rst_out_evict", out_evict, 0);
        chk("rst_out_addr", out_addr_evict, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_evict_cnt", evict_cnt, 0);
        rst = 1'b1;
        @(negedge clk);

        // Table-driven vectors, one lookup at a time with out_ready high
        for (int k = 0; k < 8; k++) begin
            out_ready = 1'b1;
            drive_req(vecs[k].tags, vecs[k].states, vecs[k].tag, vecs[k].base, vecs[k].set);
            tick();
            in_valid = 1'b0;
            #1;
            tg = vecs[k].tags;
            et = tg[TB*vecs[k].way +: TB];
            chk("tbl_out_valid", out_valid, 1);
            chk("tbl_out_way", out_way, vecs[k].way);
            chk("tbl_out_hit", out_hit, vecs[k].hit);
            chk("tbl_out_evict", out_evict, vecs[k].evict);
            chk("tbl_out_addr", out_addr_evict, {et, vecs[k].set});
            tick();
            if (k == 0) chk("hit_cnt_first", hit_cnt, 1);
        end
        drain("tbl");

        // Skid: A, B, C back to back with the output stalled
        out_ready = 1'b0;
        pop_cnt = 0;
        drive_req(32'h44332211, 12'o1111, 8'h11, 2'd0, 5'd1);  tick();
        drive_req(32'h44332211, 12'o1101, 8'h55, 2'd0, 5'd2);  tick();
        drive_req(32'h44332211, 12'o1111, 8'h66, 2'd2, 5'd3);
        #1;
        chk("skid_in_ready_low", in_ready, 0);
        chk("skid_out_valid", out_valid, 1);
        chk("skid_out_way_a", out_way, 0);
        tick();
        tick();
        chk("skid_hold_way_a", out_way, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (acc_flag) break;
        end
        chk("skid_c_accepted", acc_flag, 1);
        drain("skid");
        chk("skid_pop_count", pop_cnt, 3);

        // Flush with main and skid full and a beat on the input
        out_ready = 1'b0;
        drive_req(32'h44332211, 12'o1111, 8'h22, 2'd0, 5'd4);  tick();
        drive_req(32'h44332211, 12'o4444, 8'h77, 2'd1, 5'd5);  tick();
        drive_req(32'h44332211, 12'o1111, 8'h33, 2'd0, 5'd6);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready_after", in_ready, 1);
        drain("flush");

        // Counter saturation, then clear racing a hit pop
        out_ready = 1'b1;
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        for (int i = 0; i < CMAX - 1; i++) begin
            drive_req(32'h44332211, 12'o1111, 8'h44, 2'(i), 5'(i));
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("sat_hit_cnt_max_minus1", hit_cnt, CMAX - 1);
        drive_req(32'h44332211, 12'o1111, 8'h22, 2'd0, 5'd0); tick();
        drive_req(32'h44332211, 12'o1111, 8'h11, 2'd0, 5'd0); tick();
        drive_req(32'h44332211, 12'o1111, 8'h33, 2'd0, 5'd0); tick();
        in_valid = 1'b0;
        tick();
        chk("sat_hit_cnt_max", hit_cnt, CMAX);
        drive_req(32'h44332211, 12'o1111, 8'h11, 2'd0, 5'd0); tick();
        in_valid = 1'b0;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_wins_hit_cnt", hit_cnt, 0);

        // Reset mid-stream
        out_ready = 1'b0;
        drive_req(32'h44332211, 12'o4444, 8'h55, 2'd1, 5'd8);  tick();
        drive_req(32'h44332211, 12'o1111, 8'h33, 2'd0, 5'd9);  tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_way", out_way, 0);
        chk("midrst_evict_cnt", evict_cnt, 0);
        exp_q.delete();
        m_hit = 0; m_evict = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            tg = '0;
            st = '0;
            for (int w = 0; w < WAYS; w++) begin
                tg[TB*w +: TB] = 8'h10 + 8'($urandom_range(0, 5));
                case ($urandom_range(0, 5))
                    0:       st[STB*w +: STB] = 3'd0;
                    1, 2:    st[STB*w +: STB] = 3'd1;
                    3:       st[STB*w +: STB] = 3'd4;
                    default: st[STB*w +: STB] = 3'($urandom_range(0, 7));
                endcase
            end
            drive_req(tg, st, 8'h10 + 8'($urandom_range(0, 5)), 2'($urandom_range(0, 3)),
                      5'($urandom_range(0, 31)));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 63) == 0);
            tick();
        end
        cnt_clr = 1'b0;
        drain("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/llc_lookup_way_pipe.md
Name: llc_lookup_way_pipe

Overview:
- Parametrised, fully pipelined way-lookup stage for the LLC.
- Takes one set's tags, states and replacement base from the memory-read stage over a valid/ready channel, and resolves hit, empty-way or eviction victim.
- Holds the result in a 2-entry skid buffer so backpressure from the process stage never produces a combinational ready path.
- Adds pipeline flush plus saturating hit/evict statistics counters. Sits between the tag/state RAM read stage and the LLC process stage.

Parameters:
WAYS, 16, number of ways; power of two, 2..32
WAY_BITS, 4, log2(WAYS)
TAG_BITS, 12, tag width
SET_BITS, 9, set index width
STATE_BITS, 3, per-way state width
ST_INVALID, 0, INVALID state encoding
ST_VALID, 1, VALID state encoding
ST_SD, 4, SD state encoding
CNT_BITS, 16, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
in_valid  in  1  lookup request valid
in_ready  out  1  stage can accept a request
in_tags  in  WAYS*TAG_BITS  way i tag at bits [TAG_BITS*(i+1)-1 -: TAG_BITS]
in_states  in  WAYS*STATE_BITS  way i state, same packing
in_evict_base  in  WAY_BITS  replacement rotation base
in_tag  in  TAG_BITS  requested tag
in_set  in  SET_BITS  requested set
flush  in  1  discard all in-flight lookups
out_valid  out  1  result valid
out_ready  in  1  process stage accepts result
out_way  out  WAY_BITS  selected way
out_hit  out  1  tag hit
out_evict  out  1  victim requires eviction
out_addr_evict  out  TAG_BITS+SET_BITS  {tags[out_way], in_set} of the selected way
hit_cnt  out  CNT_BITS  saturating count of accepted hits
evict_cnt  out  CNT_BITS  saturating count of accepted evictions
cnt_clr  in  1  synchronous clear of both counters

Behaviour:
- Reset (rst=0, asynchronous): main and skid entries invalid, all data registers 0, hit_cnt=evict_cnt=0. Outputs: out_valid=0, in_ready=1, out_way=0, out_hit=0, out_evict=0, out_addr_evict=0. A reset asserted mid-operation drops all entries.
- Combinational resolve per way i:
  - hit_i = tag_i==in_tag && state_i!=ST_INVALID
  - empty_i = state_i==ST_INVALID
  - j = (i + in_evict_base) mod WAYS; valid_i = state_j==ST_VALID; notsd_i = state_j!=ST_SD
- Lowest-index priority encoding; the first matching rule wins:
  - any hit: way=hit index, hit=1, evict=0
  - else any empty: way=empty index, hit=0, evict=0
  - else any valid: way=(index+base) mod WAYS, evict=1
  - else any notsd: way=(index+base) mod WAYS, evict=1
  - else: way=base, evict=1
- All way arithmetic wraps modulo WAYS (truncate to WAY_BITS).
- Handshake:
  - Input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
  - in_ready = !skid_valid, registered with no combinational path from out_ready.
  - Latency: a result is visible on out_* the cycle after acceptance if the main entry is empty or popping that cycle.
  - If main is full and not popping, the accepted result goes to skid. On the next pop, skid moves to main and skid clears.
  - Strict FIFO order. Push and pop in the same cycle with skid empty: main loads the new result.
  - out_* are stable while out_valid && !out_ready.
- Flush (synchronous, highest priority): main and skid invalidate at the clock edge. An input beat presented in the flush cycle is dropped, not counted, and in_ready reads 1. out_valid returns 0 on the next cycle.
- Counters:
  - Increment on each output pop with out_hit (hit_cnt) or out_evict (evict_cnt).
  - Saturate at 2^CNT_BITS-1.
  - cnt_clr zeroes both and takes precedence over a same-cycle increment.
  - Not affected by flush.

Test Plan:
- WAYS=4, tags {0x11,0x22,0x33,0x44}, all states VALID, in_tag=0x33, out_ready=1 -> next cycle out_valid=1, out_way=2, out_hit=1, out_evict=0, hit_cnt=1.
- Tag miss, states {VALID,INVALID,VALID,INVALID} -> out_way=1, out_hit=0, out_evict=0.
- Miss, states {SD,SD,VALID,SD}, base=3 -> rotated valid scan finds way 2, out_evict=1, out_addr_evict={tag2,set}. Same with all SD, base=3 -> out_way=3, out_evict=1.
- out_ready=0, three back-to-back requests A,B,C -> A in main, B in skid, in_ready=0 so C is held. Raise out_ready -> A,B,C emerge in order with no drop or duplicate.
- Main and skid both full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, counters unchanged.
- Force hit_cnt to 2^CNT_BITS-2, then two accepted hits -> saturates at max. cnt_clr concurrent with a hit pop -> 0. Assert rst mid-stream -> out_valid=0 immediately.
